uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer and launch sequencer directly upstream of the UART transmitter.
- Accepts bytes from the host side at any rate into a DEPTH-entry circular FIFO.
- Presents one byte at a time to the transmitter's parallel input with a start pulse, then waits for the transmitter's busy flag to go high and back low before launching the next byte.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- DATA_W, 8, byte width; matches the transmitter's parallel input.
- ACK_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before re-pulsing tx_start.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  host write strobe; one byte per cycle.
- wr_data  input  DATA_W  host byte.
- clr_ovf  input  1  clears the sticky overflow flag.
- tx_busy  input  1  transmitter frame-in-progress flag.
- tx_data  output  DATA_W  byte to the transmitter's parallel input.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset values: tx_data=0, tx_start=0, full=0, empty=1, overflow=0, state=IDLE, rd_ptr=wr_ptr=count=0.
- Reset is asynchronous and immediate mid-frame. The FIFO contents are discarded. The byte in flight is abandoned; the transmitter is reset by the same rst_n.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is $clog2(DEPTH)+1 bits wide.
- full and empty are registered, derived from the next-state count, and valid in the same cycle as the count they describe.
- Write acceptance: a write is accepted when wr_en=1 and full=0, as sampled at the edge. The byte is stored at wr_ptr, then wr_ptr increments.
- Write while full: the byte is dropped, the pointers are unchanged, and overflow is set the next cycle. This applies even if a pop occurs in the same cycle; no write-through when full.
- Overflow flag: clr_ovf clears it. If clr_ovf and a dropped write occur in the same cycle, set wins.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- Empty-FIFO write: the byte is not visible to the sequencer until the following cycle, giving 2 cycles minimum from wr_en to tx_start.
- IDLE state: if empty=0, pop mem[rd_ptr] into tx_data, increment rd_ptr, decrement count, go to LAUNCH.
- LAUNCH state: tx_start=1 for exactly one cycle, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK state:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches ACK_TIMEOUT, go to LAUNCH to re-pulse with the same tx_data.
- WAIT_DONE state: when tx_busy=0, go to IDLE.
- tx_data is held stable from LAUNCH until the next pop.
- Throughput: with the FIFO non-empty, the next tx_start comes 2 cycles after tx_busy falls (WAIT_DONE→IDLE→LAUNCH).

Optional Feature:
- Macro: UART_TX_FIFO_LEVEL_EN.
- When defined, adds output port level[$clog2(DEPTH):0] equal to the registered count. It resets to 0 and is updated on the same edge as full and empty.
- When undefined, the port does not exist and all other behaviour is identical.

Decomposition:
- Shared uart_pkg holds:
  - UART_DATA_W = 8.
  - The sequencer state enum {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} as tx_seq_state_t.
  - The default FIFO depth constant.
- One sub-module is natural: sync_fifo (storage, pointers, count, full/empty/overflow).
- uart_tx_fifo instantiates sync_fifo and contains the launch FSM.

Test Plan:
- Reset state: hold rst_n=0 three cycles, then release -> empty=1, full=0, overflow=0, tx_start=0, tx_data=0.
- Single byte: write 0xA5 with a transmitter model that raises busy 1 cycle after start and holds it 10 cycles -> one tx_start pulse 2 cycles after wr_en with tx_data=0xA5; no further pulse.
- Ordering and wrap: burst-write 20 bytes 0x00..0x13 with DEPTH=16 and a slow transmitter -> 0x00..0x13 emitted in order across pointer wrap; empty=1 at the end.
- Overflow: stall the transmitter (busy stays high), write 18 bytes -> full after 16 accepted (one already popped, so 17 accepted total); overflow=1; dropped bytes never appear; clr_ovf pulse -> overflow=0.
- Simultaneous events: with the FIFO full, drive wr_en on the same cycle the FSM pops -> write dropped, overflow=1, count=DEPTH-1. Assert clr_ovf together with a dropped write -> overflow stays 1.
- Timeout and reset mid-frame: a transmitter model that ignores the first start -> tx_start re-pulses after ACK_TIMEOUT=4 cycles with the same tx_data. Assert rst_n low during WAIT_DONE -> all outputs reach reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: shared UART widths, default FIFO depth and tx launch sequencer states
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FIFO_DEPTH = 16;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} tx_seq_state_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write side and transmitter side of the tx FIFO; level exists only with UART_TX_FIFO_LEVEL_EN
interface uart_tx_fifo_if #(
  parameter int DATA_W = uart_pkg::UART_DATA_W,
  parameter int DEPTH = uart_pkg::UART_FIFO_DEPTH
);
  logic wr_en;
  logic [DATA_W-1:0] wr_data;
  logic clr_ovf;
  logic tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic tx_start;
  logic full;
  logic empty;
  logic overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  modport master (output wr_en, wr_data, clr_ovf, tx_busy, input tx_data, tx_start, full, empty, overflow, level);
  modport slave (input wr_en, wr_data, clr_ovf, tx_busy, output tx_data, tx_start, full, empty, overflow, level);
`else
  modport master (output wr_en, wr_data, clr_ovf, tx_busy, input tx_data, tx_start, full, empty, overflow);
  modport slave (input wr_en, wr_data, clr_ovf, tx_busy, output tx_data, tx_start, full, empty, overflow);
`endif
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: circular byte store with registered full/empty and sticky overflow
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic              i_clr_ovf,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic [AW:0]       o_count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count, w_count_nx;
  logic r_full, r_empty, r_overflow, w_wr_ok, w_rd_ok;
  assign w_wr_ok = i_wr_en && !r_full;
  assign w_rd_ok = i_rd_en && !r_empty;
  assign w_count_nx = r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full = r_full;
  assign o_empty = r_empty;
  assign o_overflow = r_overflow;
  assign o_count = r_count;
  // storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk)
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
  // pointers, occupancy and flags; a dropped write beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ok ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_rd_ok ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count <= w_count_nx;
      r_full <= w_count_nx == (AW+1)'(DEPTH);
      r_empty <= w_count_nx == '0;
      r_overflow <= (i_wr_en && r_full) ? 1'b1 : (i_clr_ovf ? 1'b0 : r_overflow);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered launch sequencer for the UART transmitter; UART_TX_FIFO_LEVEL_EN adds a level output
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  parameter int ACK_TIMEOUT = 4
) (
  input logic clk,
  input logic rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  tx_seq_state_t r_state;
  logic [DATA_W-1:0] r_tx_data, w_rd_data;
  logic r_tx_start, w_pop;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic [AW:0] w_count;
  assign w_pop = (r_state == IDLE) && (w_count != '0);
  assign w_timer_nx = r_timer + TW'(1);
  assign bus.tx_data = r_tx_data;
  assign bus.tx_start = r_tx_start;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.level = w_count;
`endif
  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_wr_en(bus.wr_en),
    .i_wr_data(bus.wr_data),
    .i_rd_en(w_pop),
    .i_clr_ovf(bus.clr_ovf),
    .o_rd_data(w_rd_data),
    .o_full(bus.full),
    .o_empty(bus.empty),
    .o_overflow(bus.overflow),
    .o_count(w_count)
  );
  // launch sequencer: pop, pulse start, re-pulse if busy never rises, wait for frame end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_tx_data <= '0;
      r_tx_start <= 1'b0;
      r_timer <= '0;
    end else
      case (r_state)
        IDLE:
          if (w_pop) begin
            r_tx_data <= w_rd_data;
            r_tx_start <= 1'b1;
            r_state <= LAUNCH;
          end
        LAUNCH: begin
          r_tx_start <= 1'b0;
          r_timer <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK:
          if (bus.tx_busy) r_state <= WAIT_DONE;
          else begin
            r_timer <= w_timer_nx;
            if (w_timer_nx == TW'(ACK_TIMEOUT)) begin
              r_tx_start <= 1'b1;
              r_state <= LAUNCH;
            end
          end
        WAIT_DONE:
          if (!bus.tx_busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the tx FIFO sequencer against a simple transmitter model
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  int rem;
  int pulses;
  int busy_len;
  int ign_idx;
  bit stall;
  logic [7:0] sent [$];
  int base;
  int p0;
  uart_tx_fifo_if bus ();
  uart_tx_fifo dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.tx_busy = stall || (rem > 0);
  // transmitter model: busy rises the cycle after an accepted start and lasts busy_len cycles
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rem <= 0;
    else if (bus.tx_start) begin
      pulses <= pulses + 1;
      if (pulses != ign_idx) begin
        rem <= busy_len;
        sent.push_back(bus.tx_data);
      end
    end else if (rem > 0) rem <= rem - 1;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    pulses = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    busy_len = 10;
    ign_idx = -1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.clr_ovf = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_data", bus.tx_data, 0);
    // single byte
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    tick(1);
    bus.wr_en = 1'b0;
    chk("sb_start_early", bus.tx_start, 0);
    chk("sb_notempty", bus.empty, 0);
    tick(1);
    chk("sb_start", bus.tx_start, 1);
    chk("sb_data", bus.tx_data, 8'hA5);
    chk("sb_empty", bus.empty, 1);
    tick(1);
    chk("sb_start_one", bus.tx_start, 0);
    tick(15);
    chk("sb_pulses", pulses, 1);
    chk("sb_sent_n", sent.size(), 1);
    chk("sb_sent", sent[0], 8'hA5);
    chk("sb_hold", bus.tx_data, 8'hA5);
    // ordering across pointer wrap
    busy_len = 1;
    base = sent.size();
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      tick(1);
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 400 && sent.size() < base + 20; k++) tick(1);
    tick(5);
    chk("wrap_n", sent.size() - base, 20);
    for (int i = 0; i < 20; i++) chk("wrap_byte", sent[base + i], 32'(i));
    chk("wrap_empty", bus.empty, 1);
    chk("wrap_ovf", bus.overflow, 0);
    // overflow with a stalled transmitter
    stall = 1'b1;
    base = sent.size();
    for (int i = 0; i < 18; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h20 + i);
      tick(1);
    end
    bus.wr_en = 1'b0;
    chk("ov_full", bus.full, 1);
    chk("ov_flag", bus.overflow, 1);
    chk("ov_empty", bus.empty, 0);
    chk("ov_sent_n", sent.size() - base, 1);
    chk("ov_first", sent[base], 8'h20);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("ov_level", bus.level, 16);
`endif
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    chk("ov_clr", bus.overflow, 0);
    chk("ov_clr_full", bus.full, 1);
    // write dropped in the same cycle as a pop
    busy_len = 30;
    stall = 1'b0;
    tick(1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hDD;
    tick(1);
    bus.wr_en = 1'b0;
    chk("sim_full", bus.full, 0);
    chk("sim_ovf", bus.overflow, 1);
    chk("sim_empty", bus.empty, 0);
    chk("sim_start", bus.tx_start, 1);
    chk("sim_data", bus.tx_data, 8'h21);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("sim_level", bus.level, 15);
`endif
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hEE;
    tick(1);
    chk("refill_full", bus.full, 1);
    bus.wr_data = 8'hEF;
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.wr_en = 1'b0;
    chk("setwins_ovf", bus.overflow, 1);
    chk("setwins_full", bus.full, 1);
    tick(1);
    bus.clr_ovf = 1'b0;
    chk("clr2_ovf", bus.overflow, 0);
    busy_len = 1;
    for (int k = 0; k < 600 && sent.size() < base + 18; k++) tick(1);
    tick(5);
    chk("drain_n", sent.size() - base, 18);
    for (int i = 0; i < 17; i++) chk("drain_byte", sent[base + i], 32'(8'h20 + i));
    chk("drain_last", sent[base + 17], 8'hEE);
    chk("drain_empty", bus.empty, 1);
    // ack timeout re-pulse
    busy_len = 10;
    base = sent.size();
    p0 = pulses;
    ign_idx = pulses;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h3C;
    tick(1);
    bus.wr_en = 1'b0;
    tick(1);
    chk("to_start1", bus.tx_start, 1);
    chk("to_data1", bus.tx_data, 8'h3C);
    tick(1);
    chk("to_gap_a", bus.tx_start, 0);
    tick(3);
    chk("to_gap_b", bus.tx_start, 0);
    tick(1);
    chk("to_start2", bus.tx_start, 1);
    chk("to_data2", bus.tx_data, 8'h3C);
    chk("to_pulses", pulses - p0, 1);
    // reset during WAIT_DONE
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h51;
    tick(1);
    bus.wr_data = 8'h52;
    tick(1);
    bus.wr_en = 1'b0;
    tick(2);
    chk("mf_busy", bus.tx_busy, 1);
    chk("mf_notempty", bus.empty, 0);
    chk("mf_sent", sent[base], 8'h3C);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_start", bus.tx_start, 0);
    chk("ar_data", bus.tx_data, 0);
    chk("ar_empty", bus.empty, 1);
    chk("ar_full", bus.full, 0);
    chk("ar_ovf", bus.overflow, 0);
    tick(1);
    rst_n = 1'b1;
    p0 = pulses;
    tick(6);
    chk("post_pulses", pulses - p0, 0);
    chk("post_empty", bus.empty, 1);
    chk("post_start", bus.tx_start, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
